// File: rtl/fetch_inst_buffer_pkg.sv
// Entry layout shared by the fetch/decode instruction buffer and its storage array.
package fetch_inst_buffer_pkg;

  localparam int W_INST      = 32;
  localparam int W_PC        = 32;
  localparam int W_PRED_ADDR = 32;
  localparam int W_MMU_FLAGS = 14;

  localparam int OFF_INST      = 0;
  localparam int OFF_PC        = OFF_INST + W_INST;
  localparam int OFF_PRED_ADDR = OFF_PC + W_PC;
  localparam int OFF_MMU_FLAGS = OFF_PRED_ADDR + W_PRED_ADDR;
  localparam int OFF_PF        = OFF_MMU_FLAGS + W_MMU_FLAGS;
  localparam int OFF_PAGING    = OFF_PF + 1;
  localparam int OFF_KERNEL    = OFF_PAGING + 1;
  localparam int OFF_PRED      = OFF_KERNEL + 1;

  localparam int ENTRY_W = OFF_PRED + 1;

endpackage

// File: rtl/fetch_inst_buffer_ram.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one asynchronous read port.
module fetch_inst_buffer_ram
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_N-1:0] waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [DEPTH_N-1:0] raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Entry write; contents are only ever read after being written since the last flush/reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_inst_buffer.sv
// In-order queue between fetch and decode with full-lock back-pressure.
// Optional pagefault fetch-stop flag: MIST1032ISA_INST_BUFFER_FAULT_STOP_EN.
module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic                   iCLOCK,
  input  logic                   iRESET_SYNC,
  input  logic                   iFLUSH,
  input  logic                   iPREVIOUS_INST_VALID,
  input  logic [31:0]            iPREVIOUS_INST,
  input  logic [31:0]            iPREVIOUS_PC,
  input  logic                   iPREVIOUS_PAGEFAULT,
  input  logic [13:0]            iPREVIOUS_MMU_FLAGS,
  input  logic                   iPREVIOUS_PAGING_ENA,
  input  logic                   iPREVIOUS_KERNEL_ACCESS,
  input  logic                   iPREVIOUS_BRANCH_PREDICT,
  input  logic [31:0]            iPREVIOUS_BRANCH_PREDICT_ADDR,
  output logic                   oPREVIOUS_LOCK,
  output logic                   oPREVIOUS_FETCH_STOP,
  output logic                   oNEXT_INST_VALID,
  output logic [31:0]            oNEXT_INST,
  output logic [31:0]            oNEXT_PC,
  output logic                   oNEXT_PAGEFAULT,
  output logic [13:0]            oNEXT_MMU_FLAGS,
  output logic                   oNEXT_PAGING_ENA,
  output logic                   oNEXT_KERNEL_ACCESS,
  output logic                   oNEXT_BRANCH_PREDICT,
  output logic [31:0]            oNEXT_BRANCH_PREDICT_ADDR,
  input  logic                   iNEXT_LOCK,
  output logic [DEPTH_N:0]       oCOUNT
);

  localparam logic [DEPTH_N:0]   FULL_COUNT = (DEPTH_N+1)'(DEPTH);
  localparam logic [DEPTH_N:0]   CNT_ONE    = (DEPTH_N+1)'(1);
  localparam logic [DEPTH_N-1:0] PTR_ONE    = DEPTH_N'(1);

  logic [DEPTH_N-1:0] wp_r;
  logic [DEPTH_N-1:0] rp_r;
  logic [DEPTH_N:0]   count_r;
  logic               push_s;
  logic               pop_s;
  logic [ENTRY_W-1:0] wr_data_s;
  logic [ENTRY_W-1:0] rd_data_s;

  // Lock comes from the registered count only, so a same-cycle pop never frees a full slot.
  assign oPREVIOUS_LOCK   = (count_r == FULL_COUNT);
  assign oNEXT_INST_VALID = (count_r != {(DEPTH_N+1){1'b0}});
  assign push_s = iPREVIOUS_INST_VALID && !oPREVIOUS_LOCK && !iFLUSH;
  assign pop_s  = oNEXT_INST_VALID && !iNEXT_LOCK && !iFLUSH;
  assign oCOUNT = count_r;

  // Pack the fetch fields into one entry word.
  always_comb begin
    wr_data_s = {ENTRY_W{1'b0}};
    wr_data_s[OFF_INST +: W_INST]           = iPREVIOUS_INST;
    wr_data_s[OFF_PC +: W_PC]               = iPREVIOUS_PC;
    wr_data_s[OFF_PRED_ADDR +: W_PRED_ADDR] = iPREVIOUS_BRANCH_PREDICT_ADDR;
    wr_data_s[OFF_MMU_FLAGS +: W_MMU_FLAGS] = iPREVIOUS_MMU_FLAGS;
    wr_data_s[OFF_PF]                       = iPREVIOUS_PAGEFAULT;
    wr_data_s[OFF_PAGING]                   = iPREVIOUS_PAGING_ENA;
    wr_data_s[OFF_KERNEL]                   = iPREVIOUS_KERNEL_ACCESS;
    wr_data_s[OFF_PRED]                     = iPREVIOUS_BRANCH_PREDICT;
  end

  // Pointer and occupancy control; flush and reset both empty the queue.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iFLUSH) begin
      wp_r    <= {DEPTH_N{1'b0}};
      rp_r    <= {DEPTH_N{1'b0}};
      count_r <= {(DEPTH_N+1){1'b0}};
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PTR_ONE;
      end
      if (pop_s) begin
        rp_r <= rp_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef MIST1032ISA_INST_BUFFER_FAULT_STOP_EN
  logic stop_r;

  // Sticky stop once a faulting word is accepted, until the exception flush.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iFLUSH) begin
      stop_r <= 1'b0;
    end else if (push_s && iPREVIOUS_PAGEFAULT) begin
      stop_r <= 1'b1;
    end else begin
      stop_r <= stop_r;
    end
  end

  assign oPREVIOUS_FETCH_STOP = stop_r;
`else
  assign oPREVIOUS_FETCH_STOP = 1'b0;
`endif

  fetch_inst_buffer_ram #(
    .DEPTH   (DEPTH),
    .DEPTH_N (DEPTH_N)
  ) u_ram (
    .clk   (iCLOCK),
    .we    (push_s),
    .waddr (wp_r),
    .wdata (wr_data_s),
    .raddr (rp_r),
    .rdata (rd_data_s)
  );

  assign oNEXT_INST                = rd_data_s[OFF_INST +: W_INST];
  assign oNEXT_PC                  = rd_data_s[OFF_PC +: W_PC];
  assign oNEXT_BRANCH_PREDICT_ADDR = rd_data_s[OFF_PRED_ADDR +: W_PRED_ADDR];
  assign oNEXT_MMU_FLAGS           = rd_data_s[OFF_MMU_FLAGS +: W_MMU_FLAGS];
  assign oNEXT_PAGEFAULT           = rd_data_s[OFF_PF];
  assign oNEXT_PAGING_ENA          = rd_data_s[OFF_PAGING];
  assign oNEXT_KERNEL_ACCESS       = rd_data_s[OFF_KERNEL];
  assign oNEXT_BRANCH_PREDICT      = rd_data_s[OFF_PRED];

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Directed scoreboard bench for fetch_inst_buffer (DEPTH=4); honours MIST1032ISA_INST_BUFFER_FAULT_STOP_EN.
module tb_fetch_inst_buffer;

  localparam int DEPTH = 4;
`ifdef MIST1032ISA_INST_BUFFER_FAULT_STOP_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, next_lock;
  logic [31:0] in_inst, in_pc, in_bpa;
  logic        in_pf, in_paging, in_kernel, in_bp;
  logic [13:0] in_mmu;
  logic        prev_lock, fetch_stop, out_valid;
  logic [31:0] out_inst, out_pc, out_bpa;
  logic        out_pf, out_paging, out_kernel, out_bp;
  logic [13:0] out_mmu;
  logic [2:0]  out_count;

  always #5 clk = ~clk;

  fetch_inst_buffer #(.DEPTH(4), .DEPTH_N(2)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
    .iPREVIOUS_INST_VALID(in_valid), .iPREVIOUS_INST(in_inst), .iPREVIOUS_PC(in_pc),
    .iPREVIOUS_PAGEFAULT(in_pf), .iPREVIOUS_MMU_FLAGS(in_mmu), .iPREVIOUS_PAGING_ENA(in_paging),
    .iPREVIOUS_KERNEL_ACCESS(in_kernel), .iPREVIOUS_BRANCH_PREDICT(in_bp),
    .iPREVIOUS_BRANCH_PREDICT_ADDR(in_bpa),
    .oPREVIOUS_LOCK(prev_lock), .oPREVIOUS_FETCH_STOP(fetch_stop),
    .oNEXT_INST_VALID(out_valid), .oNEXT_INST(out_inst), .oNEXT_PC(out_pc),
    .oNEXT_PAGEFAULT(out_pf), .oNEXT_MMU_FLAGS(out_mmu), .oNEXT_PAGING_ENA(out_paging),
    .oNEXT_KERNEL_ACCESS(out_kernel), .oNEXT_BRANCH_PREDICT(out_bp),
    .oNEXT_BRANCH_PREDICT_ADDR(out_bpa),
    .iNEXT_LOCK(next_lock), .oCOUNT(out_count)
  );

  logic [113:0] exp_q[$];
  logic [113:0] cur;
  int  seq, words_left, checks_total, checks_passed;
  bit  fault_next, m_stop;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks_total++;
    assert (obs === expv) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Fetch word k: PC = 4*(k+1), other fields derived from k.
  task automatic apply_word(input int k);
    in_inst   = 32'hA500_0000 | k;
    in_pc     = 32'(k + 1) * 32'd4;
    in_bpa    = ~in_inst;
    in_mmu    = 14'(k * 3 + 1);
    in_paging = k[0];
    in_kernel = k[1];
    in_bp     = k[2];
    in_pf     = fault_next;
    cur = {in_bp, in_kernel, in_paging, in_pf, in_mmu, in_bpa, in_pc, in_inst};
  endtask

  // Check outputs against the model, then advance one clock.
  task automatic cycle();
    bit push, pop;
    chk("valid", out_valid, exp_q.size() != 0);
    chk("lock", prev_lock, exp_q.size() == DEPTH);
    chk("count", out_count, exp_q.size());
    chk("stop", fetch_stop, m_stop);
    if (exp_q.size() != 0)
      chk("head", {out_bp, out_kernel, out_paging, out_pf, out_mmu, out_bpa, out_pc, out_inst}, exp_q[0]);
    push = in_valid && (exp_q.size() != DEPTH) && !flush && !rst;
    pop  = (exp_q.size() != 0) && !next_lock && !flush && !rst;
    @(posedge clk);
    #1;
    if (rst || flush) begin
      exp_q.delete();
      m_stop = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(cur);
        if (cur[110] && FAULT_EN) m_stop = 1'b1;
      end
    end
    if (push) begin
      words_left--;
      seq++;
      fault_next = 1'b0;
      apply_word(seq);
    end
    in_valid = (words_left != 0);
  endtask

  task automatic run_until(input bit drain, input string tag);
    int n = 0;
    while ((words_left != 0 || (drain && exp_q.size() != 0)) && n < 200) begin
      cycle();
      n++;
    end
    chk(tag, n < 200, 1'b1);
  endtask

  initial begin
    checks_total = 0; checks_passed = 0;
    seq = 0; words_left = 0; fault_next = 1'b0; m_stop = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; next_lock = 1'b0;
    apply_word(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    // Reset state
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_lock", prev_lock, 1'b0);
    chk("rst_stop", fetch_stop, 1'b0);
    chk("rst_count", out_count, 3'd0);

    // Stream 8 words, PCs 0x4..0x20
    words_left = 8; in_valid = 1'b1;
    run_until(1'b1, "stream_bound");

    // Fill to full with decode stalled, 5th word held, then release
    next_lock = 1'b1; words_left = 5; in_valid = 1'b1;
    repeat (8) cycle();
    chk("fill_count", out_count, 3'd4);
    chk("fill_lock", prev_lock, 1'b1);
    chk("fill_held", words_left, 1);
    next_lock = 1'b0;
    run_until(1'b1, "fill_bound");

    // Reach count 2, then 16 words with simultaneous push/pop (wraps pointers)
    next_lock = 1'b1; words_left = 18; in_valid = 1'b1;
    cycle(); cycle();
    chk("pp_count2", out_count, 3'd2);
    next_lock = 1'b0;
    repeat (5) begin
      cycle();
      chk("pp_steady", out_count, 3'd2);
    end
    run_until(1'b1, "wrap_bound");

    // Flush at count 3 with a word presented
    next_lock = 1'b1; words_left = 3; in_valid = 1'b1;
    run_until(1'b0, "flush_fill_bound");
    chk("pre_flush_count", out_count, 3'd3);
    words_left = 1; in_valid = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; words_left = 0; in_valid = 1'b0;
    chk("flush_count", out_count, 3'd0);
    chk("flush_valid", out_valid, 1'b0);
    cycle();
    seq++; apply_word(seq);
    next_lock = 1'b0; words_left = 1; in_valid = 1'b1;
    run_until(1'b1, "post_flush_bound");

    // Pagefault push and fetch-stop hold until flush
    fault_next = 1'b1; apply_word(seq);
    words_left = 1; in_valid = 1'b1;
    cycle();
    chk("fault_stop", fetch_stop, FAULT_EN);
    repeat (10) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fault_cleared", fetch_stop, 1'b0);
    cycle();

    // Reset in mid-operation at count 3
    next_lock = 1'b1; words_left = 3; in_valid = 1'b1;
    run_until(1'b0, "rst_fill_bound");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_lock", prev_lock, 1'b0);
    chk("mid_rst_stop", fetch_stop, 1'b0);
    chk("mid_rst_count", out_count, 3'd0);
    cycle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
